// File: rtl/periph_bus_bridge.sv
// CPU load/store to peripheral slave bus bridge: window decode, one-shot strobe, registered response.
// Optional first-error address capture is enabled by defining PERIPH_ERR_CAPTURE_EN.
module periph_bus_bridge #(
    parameter int          N_SLAVES    = 4,
    parameter logic [3:0]  PERIPH_BASE = 4'hF,
    parameter int          SEL_LSB     = 8,
    parameter int          OFS_MSB     = 7
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst,
    input  logic                     i_Req,
    input  logic                     i_We,
    input  logic [31:0]              i_Addr,
    input  logic [31:0]              i_WData,
    output logic                     o_Ready,
    output logic                     o_Done,
    output logic [31:0]              o_RData,
    output logic                     o_Err,
    output logic [N_SLAVES-1:0]      o_S_WEnable,
    output logic [N_SLAVES-1:0]      o_S_REnable,
    output logic [31:0]              o_S_WAddr,
    output logic [31:0]              o_S_RAddr,
    output logic [31:0]              o_S_WData,
    input  logic [32*N_SLAVES-1:0]   i_S_RData,
`ifdef PERIPH_ERR_CAPTURE_EN
    output logic [31:0]              o_ErrAddr,
    output logic                     o_ErrValid,
    input  logic                     i_ErrClr,
`endif
    input  logic [N_SLAVES-1:0]      i_S_Err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state_q, state_d;
    logic                 we_q, we_d;
    logic [3:0]           sel_q, sel_d;
    logic [OFS_MSB-2:0]   ofs_q, ofs_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [31:0]          addr_q, addr_d;

    logic [3:0]           idx;
    logic                 hit;
    logic                 accept;
    logic                 sel_err;
    logic [31:0]          sel_rdata;
    logic                 unused_addr;

    assign idx         = i_Addr[SEL_LSB+3:SEL_LSB];
    assign hit         = (i_Addr[31:28] == PERIPH_BASE) && ({1'b0, idx} < 5'(N_SLAVES))
                         && (i_Addr[1:0] == 2'b00);
    assign accept      = (state_q == IDLE) && i_Req;
    assign unused_addr = ^addr_q;

    // Response mux; the index is always in range once ISSUE was entered.
    always_comb begin
        sel_err   = 1'b0;
        sel_rdata = 32'h0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (sel_q == 4'(k)) begin
                sel_err   = i_S_Err[k];
                sel_rdata = i_S_RData[32*k +: 32];
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_Req) state_d = hit ? ISSUE : RESP;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_Ready     = (state_q == IDLE);
        o_Done      = (state_q == RESP);
        o_S_WEnable = '0;
        o_S_REnable = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (state_q == ISSUE && sel_q == 4'(k)) begin
                o_S_WEnable[k] = we_q;
                o_S_REnable[k] = ~we_q;
            end
        end
    end

    always_comb begin
        we_d    = we_q;
        sel_d   = sel_q;
        ofs_d   = ofs_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        addr_d  = addr_q;
        if (accept) begin
            we_d    = i_We;
            sel_d   = idx;
            ofs_d   = i_Addr[OFS_MSB:2];
            wdata_d = i_WData;
            addr_d  = i_Addr;
            if (!hit) begin
                err_d   = 1'b1;
                rdata_d = 32'h0;
            end
        end
        if (state_q == WAIT) begin
            err_d   = sel_err;
            rdata_d = (we_q || sel_err) ? 32'h0 : sel_rdata;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            we_q    <= 1'b0;
            sel_q   <= '0;
            ofs_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            we_q    <= we_d;
            sel_q   <= sel_d;
            ofs_q   <= ofs_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
        end
    end

    assign o_RData   = rdata_q;
    assign o_Err     = err_q;
    assign o_S_WAddr = {{(33-OFS_MSB){1'b0}}, ofs_q};
    assign o_S_RAddr = {{(33-OFS_MSB){1'b0}}, ofs_q};
    assign o_S_WData = wdata_q;

`ifdef PERIPH_ERR_CAPTURE_EN
    logic        errvalid_q, errvalid_d;
    logic [31:0] erraddr_q, erraddr_d;

    // A clear in the completion cycle beats the new error.
    always_comb begin
        errvalid_d = errvalid_q;
        erraddr_d  = erraddr_q;
        if (i_ErrClr) begin
            errvalid_d = 1'b0;
        end else if (state_q == RESP && err_q && !errvalid_q) begin
            errvalid_d = 1'b1;
            erraddr_d  = addr_q;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            errvalid_q <= 1'b0;
            erraddr_q  <= '0;
        end else begin
            errvalid_q <= errvalid_d;
            erraddr_q  <= erraddr_d;
        end
    end

    assign o_ErrValid = errvalid_q;
    assign o_ErrAddr  = erraddr_q;
`endif

endmodule

// File: tb/tb_periph_bus_bridge.sv
// Directed bench for periph_bus_bridge with a registered GPIO-like slave on index 0.
module tb_periph_bus_bridge;

    logic          i_Clk = 1'b0;
    logic          i_Rst;
    logic          i_Req;
    logic          i_We;
    logic [31:0]   i_Addr;
    logic [31:0]   i_WData;
    logic          o_Ready;
    logic          o_Done;
    logic [31:0]   o_RData;
    logic          o_Err;
    logic [3:0]    o_S_WEnable;
    logic [3:0]    o_S_REnable;
    logic [31:0]   o_S_WAddr;
    logic [31:0]   o_S_RAddr;
    logic [31:0]   o_S_WData;
    logic [127:0]  i_S_RData;
    logic [3:0]    i_S_Err;
`ifdef PERIPH_ERR_CAPTURE_EN
    logic [31:0]   o_ErrAddr;
    logic          o_ErrValid;
    logic          i_ErrClr;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [16];
    logic [31:0] s0_rdata = 32'h0;
    logic        s0_err = 1'b0;

    always #5 i_Clk = ~i_Clk;

    // Slave 0: registered read data, error on reads of offset 3.
    always @(posedge i_Clk) begin
        if (o_S_WEnable[0]) mem[o_S_WAddr[3:0]] <= o_S_WData;
        if (o_S_REnable[0]) s0_rdata <= mem[o_S_RAddr[3:0]];
        if (o_S_WEnable[0] | o_S_REnable[0]) s0_err <= o_S_REnable[0] && (o_S_RAddr == 32'd3);
    end

    assign i_S_RData = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, s0_rdata};
    assign i_S_Err   = {1'b1, 1'b0, 1'b0, s0_err};

    periph_bus_bridge dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Req(i_Req), .i_We(i_We),
        .i_Addr(i_Addr), .i_WData(i_WData),
        .o_Ready(o_Ready), .o_Done(o_Done), .o_RData(o_RData), .o_Err(o_Err),
        .o_S_WEnable(o_S_WEnable), .o_S_REnable(o_S_REnable),
        .o_S_WAddr(o_S_WAddr), .o_S_RAddr(o_S_RAddr), .o_S_WData(o_S_WData),
        .i_S_RData(i_S_RData),
`ifdef PERIPH_ERR_CAPTURE_EN
        .o_ErrAddr(o_ErrAddr), .o_ErrValid(o_ErrValid), .i_ErrClr(i_ErrClr),
`endif
        .i_S_Err(i_S_Err)
    );

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction, checked cycle by cycle against hand-supplied expectations.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic hit, input int sel, input logic [31:0] ofs,
                           input logic [31:0] rdata, input logic err);
        logic [3:0] oh;
        oh = 4'b0001 << sel;
        chk("ready_before", {31'b0, o_Ready}, 32'd1);
        i_Req = 1'b1; i_We = we; i_Addr = addr; i_WData = wdata;
        tick();
        i_Req = 1'b0;
        if (hit) begin
            chk("issue_wen", {28'b0, o_S_WEnable}, we ? {28'b0, oh} : 32'd0);
            chk("issue_ren", {28'b0, o_S_REnable}, we ? 32'd0 : {28'b0, oh});
            chk("issue_waddr", o_S_WAddr, ofs);
            chk("issue_raddr", o_S_RAddr, ofs);
            if (we) chk("issue_wdata", o_S_WData, wdata);
            chk("issue_ready", {31'b0, o_Ready}, 32'd0);
            chk("issue_done", {31'b0, o_Done}, 32'd0);
            tick();
            chk("wait_strobes", {24'b0, o_S_WEnable, o_S_REnable}, 32'd0);
            chk("wait_done", {31'b0, o_Done}, 32'd0);
            tick();
        end else begin
            chk("miss_strobes", {24'b0, o_S_WEnable, o_S_REnable}, 32'd0);
        end
        chk("resp_done", {31'b0, o_Done}, 32'd1);
        chk("resp_rdata", o_RData, rdata);
        chk("resp_err", {31'b0, o_Err}, {31'b0, err});
        tick();
        chk("after_done", {31'b0, o_Done}, 32'd0);
        chk("after_ready", {31'b0, o_Ready}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        i_Rst = 1'b1; i_Req = 1'b0; i_We = 1'b0; i_Addr = 32'h0; i_WData = 32'h0;
`ifdef PERIPH_ERR_CAPTURE_EN
        i_ErrClr = 1'b0;
`endif
        tick(); tick();
        chk("rst_ready", {31'b0, o_Ready}, 32'd1);
        chk("rst_done", {31'b0, o_Done}, 32'd0);
        chk("rst_rdata", o_RData, 32'h0);
        chk("rst_err", {31'b0, o_Err}, 32'd0);
        chk("rst_strobes", {24'b0, o_S_WEnable, o_S_REnable}, 32'd0);
        chk("rst_waddr", o_S_WAddr, 32'h0);
        chk("rst_raddr", o_S_RAddr, 32'h0);
        chk("rst_wdata", o_S_WData, 32'h0);
        i_Rst = 1'b0;
        tick();

        //      we    addr          wdata         hit  sel ofs  rdata         err
        run_txn(1'b1, 32'hF0000000, 32'h0000000F, 1'b1, 0, 32'd0, 32'h0,        1'b0);
        run_txn(1'b1, 32'hF0000004, 32'h00000005, 1'b1, 0, 32'd1, 32'h0,        1'b0);
        run_txn(1'b1, 32'hF000000C, 32'h00000077, 1'b1, 0, 32'd3, 32'h0,        1'b0);
        run_txn(1'b0, 32'hF0000004, 32'h0,        1'b1, 0, 32'd1, 32'h00000005, 1'b0);
        run_txn(1'b0, 32'hF0000000, 32'h0,        1'b1, 0, 32'd0, 32'h0000000F, 1'b0);
        run_txn(1'b0, 32'hF000000C, 32'h0,        1'b1, 0, 32'd3, 32'h0,        1'b1);
        run_txn(1'b0, 32'hE0000000, 32'h0,        1'b0, 0, 32'd0, 32'h0,        1'b1);
        run_txn(1'b0, 32'hF0000402, 32'h0,        1'b0, 0, 32'd0, 32'h0,        1'b1);
        run_txn(1'b0, 32'hF0000002, 32'h0,        1'b0, 0, 32'd0, 32'h0,        1'b1);
        run_txn(1'b0, 32'hF0000F00, 32'h0,        1'b0, 0, 32'd0, 32'h0,        1'b1);
        run_txn(1'b0, 32'hF0000208, 32'h0,        1'b1, 2, 32'd2, 32'hA2A2A2A2, 1'b0);
        run_txn(1'b0, 32'hF0000300, 32'h0,        1'b1, 3, 32'd0, 32'h0,        1'b1);
        run_txn(1'b1, 32'hF0000124, 32'h12345678, 1'b1, 1, 32'd9, 32'h0,        1'b0);
        run_txn(1'b1, 32'hF0000004, 32'h00000005, 1'b1, 0, 32'd1, 32'h0,        1'b0);

        // Reset during WAIT of a read abandons it.
        i_Req = 1'b1; i_We = 1'b0; i_Addr = 32'hF0000004;
        tick();
        i_Req = 1'b0;
        tick();
        i_Rst = 1'b1;
        tick();
        i_Rst = 1'b0;
        chk("midrst_done", {31'b0, o_Done}, 32'd0);
        chk("midrst_strobes", {24'b0, o_S_WEnable, o_S_REnable}, 32'd0);
        chk("midrst_ready", {31'b0, o_Ready}, 32'd1);
        tick();
        chk("midrst_done2", {31'b0, o_Done}, 32'd0);
        run_txn(1'b0, 32'hF0000004, 32'h0,        1'b1, 0, 32'd1, 32'h00000005, 1'b0);

`ifdef PERIPH_ERR_CAPTURE_EN
        chk("cap_clear_after_rst", {31'b0, o_ErrValid}, 32'd0);
        run_txn(1'b0, 32'hE0000000, 32'h0,        1'b0, 0, 32'd0, 32'h0,        1'b1);
        run_txn(1'b0, 32'hF000000C, 32'h0,        1'b1, 0, 32'd3, 32'h0,        1'b1);
        chk("cap_valid", {31'b0, o_ErrValid}, 32'd1);
        chk("cap_addr", o_ErrAddr, 32'hE0000000);
        i_ErrClr = 1'b1;
        tick();
        i_ErrClr = 1'b0;
        chk("cap_cleared", {31'b0, o_ErrValid}, 32'd0);
        run_txn(1'b0, 32'hF0000F00, 32'h0,        1'b0, 0, 32'd0, 32'h0,        1'b1);
        chk("cap_valid2", {31'b0, o_ErrValid}, 32'd1);
        chk("cap_addr2", o_ErrAddr, 32'hF0000F00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
